// File: rtl/clkdiv_multi.sv
// Multi-channel clock-enable generator: per-channel tick strobe and square wave,
// runtime-reloadable dividers applied at period boundaries, gated by a settle qualifier.
module clkdiv_multi #(
  parameter int unsigned NCH         = 4,
  parameter int unsigned DIV_W       = 16,
  parameter int unsigned DEF_DIV     = 300,
  parameter int unsigned LOCK_CYCLES = 64
) (
  input  logic             clkin,
  input  logic             reset,
  input  logic [NCH-1:0]   ch_en,
  input  logic             cfg_wr,
  input  logic [2:0]       cfg_ch,
  input  logic [DIV_W-1:0] cfg_div,
  output logic             cfg_err,
  output logic [NCH-1:0]   pend,
  output logic             lock,
  output logic [NCH-1:0]   tick,
  output logic [NCH-1:0]   sq
);

  localparam int unsigned SET_W = $clog2(LOCK_CYCLES + 1);

  logic [SET_W-1:0] settle;
  logic             cfg_ok;

  assign cfg_ok = cfg_wr && (32'(cfg_ch) < NCH) && (cfg_div >= DIV_W'(2));

  // Settle counter saturates at LOCK_CYCLES; lock is sticky until reset.
  always_ff @(posedge clkin) begin
    if (reset) begin
      settle <= '0;
      lock   <= 1'b0;
    end else if (settle != SET_W'(LOCK_CYCLES)) begin
      settle <= settle + SET_W'(1);
      if (settle == SET_W'(LOCK_CYCLES - 1)) lock <= 1'b1;
    end
  end

  always_ff @(posedge clkin) begin
    if (reset) cfg_err <= 1'b0;
    else       cfg_err <= cfg_wr && !cfg_ok;
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] div;
    logic [DIV_W-1:0] pdiv;
    logic             pend_q;
    logic             tick_q;
    logic             sq_q;
    logic             run;
    logic             bnd;
    logic             hit;
    logic             apply;

    assign run   = lock & ch_en[i];
    assign bnd   = run && (cnt == div - DIV_W'(1));
    assign hit   = cfg_ok && (cfg_ch == 3'(i));
    assign apply = pend_q && (!run || bnd);

    // A write landing on the boundary edge bypasses the pending register.
    always_ff @(posedge clkin) begin
      if (reset) begin
        cnt    <= '0;
        div    <= DIV_W'(DEF_DIV);
        pdiv   <= '0;
        pend_q <= 1'b0;
        tick_q <= 1'b0;
        sq_q   <= 1'b0;
      end else begin
        tick_q <= bnd;
        sq_q   <= run && (cnt < (div >> 1));
        cnt    <= (!run || bnd) ? '0 : cnt + DIV_W'(1);
        if (hit && bnd) begin
          div    <= cfg_div;
          pend_q <= 1'b0;
        end else begin
          if (apply) begin
            div    <= pdiv;
            pend_q <= 1'b0;
          end
          if (hit) begin
            pdiv   <= cfg_div;
            pend_q <= 1'b1;
          end
        end
      end
    end

    assign pend[i] = pend_q;
    assign tick[i] = tick_q;
    assign sq[i]   = sq_q;
  end

endmodule

// File: tb/tb_clkdiv_multi.sv
// Scoreboard bench for clkdiv_multi: a driver advances a behavioural model and
// queues expected outputs; a negedge monitor pops and compares them.
module tb_clkdiv_multi;

  localparam int unsigned NCH   = 3;
  localparam int unsigned DIV_W = 16;
  localparam int unsigned DEF   = 300;
  localparam int unsigned LOCKC = 64;

  logic             clkin = 1'b0;
  logic             reset = 1'b1;
  logic [NCH-1:0]   ch_en = '0;
  logic             cfg_wr = 1'b0;
  logic [2:0]       cfg_ch = '0;
  logic [DIV_W-1:0] cfg_div = '0;
  logic             cfg_err;
  logic [NCH-1:0]   pend;
  logic             lock;
  logic [NCH-1:0]   tick;
  logic [NCH-1:0]   sq;

  clkdiv_multi #(.NCH(NCH), .DIV_W(DIV_W), .DEF_DIV(DEF), .LOCK_CYCLES(LOCKC)) dut (
    .clkin(clkin), .reset(reset), .ch_en(ch_en), .cfg_wr(cfg_wr), .cfg_ch(cfg_ch),
    .cfg_div(cfg_div), .cfg_err(cfg_err), .pend(pend), .lock(lock), .tick(tick), .sq(sq)
  );

  always #5 clkin = ~clkin;

  typedef struct {
    logic [NCH-1:0] tick;
    logic [NCH-1:0] sq;
    logic [NCH-1:0] pend;
    logic           lock;
    logic           err;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // Model state: position within the current period, divide values, release age.
  int phase[NCH];
  int dv[NCH];
  int pv[NCH];
  bit pf[NCH];
  int age;
  bit mlock;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      if (errors <= 30)
        $display("FAIL %s at %0t: got %b expected %b", name, $time, act, want);
    end
  endtask

  always @(negedge clkin) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("tick", 8'(tick), 8'(e.tick));
      check("sq", 8'(sq), 8'(e.sq));
      check("pend", 8'(pend), 8'(e.pend));
      check("lock", 8'(lock), 8'(e.lock));
      check("cfg_err", 8'(cfg_err), 8'(e.err));
    end
  end

  // One clock edge: the model consumes the inputs that were present at the edge.
  task automatic cycle();
    exp_t e;
    bit   lk;
    bit   ok;
    @(posedge clkin);
    e.tick = '0; e.sq = '0; e.pend = '0; e.err = 1'b0;
    lk = mlock;
    ok = cfg_wr && (int'(cfg_ch) < NCH) && (int'(cfg_div) >= 2);
    if (reset) begin
      age = 0; mlock = 0;
      for (int i = 0; i < NCH; i++) begin
        phase[i] = 0; dv[i] = DEF; pv[i] = 0; pf[i] = 0;
      end
    end else begin
      e.err = cfg_wr && !ok;
      for (int i = 0; i < NCH; i++) begin
        bit run, last;
        run  = lk && ch_en[i];
        last = run && (phase[i] == dv[i] - 1);
        e.tick[i] = last;
        e.sq[i]   = run && (phase[i] < dv[i] / 2);
        phase[i]  = (run && !last) ? phase[i] + 1 : 0;
        if (ok && int'(cfg_ch) == i && last) begin
          dv[i] = int'(cfg_div); pf[i] = 0;
        end else begin
          if (pf[i] && (!run || last)) begin
            dv[i] = pv[i]; pf[i] = 0;
          end
          if (ok && int'(cfg_ch) == i) begin
            pv[i] = int'(cfg_div); pf[i] = 1;
          end
        end
      end
      if (age < LOCKC) age++;
      mlock = (age >= LOCKC);
    end
    for (int i = 0; i < NCH; i++) e.pend[i] = pf[i];
    e.lock = mlock;
    exp_q.push_back(e);
    #1;
    cfg_wr = 1'b0;
  endtask

  task automatic run_cycles(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  task automatic write(input int ch, input int dvn);
    cfg_wr = 1'b1; cfg_ch = 3'(ch); cfg_div = DIV_W'(dvn);
    cycle();
  endtask

  // Advance until the model says channel ch sits at position pos; bounded.
  task automatic wait_phase(input int ch, input int pos);
    int k;
    k = 0;
    while (phase[ch] != pos && k < 2000) begin
      cycle(); k++;
    end
    checks++;
    if (phase[ch] != pos) begin
      errors++;
      $display("FAIL wait_phase ch%0d: got %0d expected %0d", ch, phase[ch], pos);
    end
  endtask

  initial begin
    age = 0; mlock = 0;
    for (int i = 0; i < NCH; i++) begin
      phase[i] = 0; dv[i] = DEF; pv[i] = 0; pf[i] = 0;
    end
    // Lock timing with all channels enabled through settle.
    reset = 1'b1; ch_en = '1;
    run_cycles(3);
    reset = 1'b0;
    run_cycles(70);

    // Default carrier, enabled after lock.
    reset = 1'b1; ch_en = '0;
    run_cycles(1);
    reset = 1'b0;
    run_cycles(66);
    ch_en = '1;
    run_cycles(650);

    // Runtime reload of ch1 mid-period.
    wait_phase(1, 100);
    write(1, 10);
    run_cycles(260);

    // Boundary write on ch2.
    wait_phase(2, 299);
    write(2, 7);
    run_cycles(30);

    // Rejects and the minimum legal divider.
    write(3, 50);
    run_cycles(5);
    write(0, 1);
    run_cycles(5);
    write(7, 0);
    write(0, 2);
    run_cycles(20);

    // Reset mid-run with a write pending.
    write(1, 20);
    write(2, 40);
    reset = 1'b1;
    run_cycles(1);
    reset = 1'b0;
    run_cycles(400);

    // Randomised enables, writes (legal and illegal) and occasional resets.
    for (int k = 0; k < 3500; k++) begin
      if ($urandom_range(0, 99) < 4) ch_en[$urandom_range(0, NCH - 1)] ^= 1'b1;
      if ($urandom_range(0, 99) < 5) begin
        cfg_wr  = 1'b1;
        cfg_ch  = 3'($urandom_range(0, 7) < 6 ? $urandom_range(0, NCH - 1) : $urandom_range(0, 7));
        cfg_div = DIV_W'($urandom_range(0, 9) < 8 ? $urandom_range(0, 13) : $urandom_range(2, 400));
      end
      reset = ($urandom_range(0, 999) < 2);
      cycle();
    end
    reset = 1'b0;
    run_cycles(2);
    @(negedge clkin);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d queued expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
